// File: rtl/seg_pkg.sv
// seg_pkg: constants and types shared by the 7-segment scan controller.
package seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Active-low g..a patterns, entry 15 first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_e;
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        return HEX_SEG[v];
    endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: host-side write, commit and mask bundle of the scan controller.
interface seg_scan_ctrl_if #(parameter int NDIG = 4);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [$clog2(NDIG)-1:0] wr_idx;
    logic [3:0]              wr_data;
    logic                    commit;
    logic                    busy;
    logic [NDIG-1:0]         en_mask;
    logic [NDIG-1:0]         blink_mask;
    modport master (
        output wr_valid, wr_idx, wr_data, commit, en_mask, blink_mask,
        input  wr_ready, busy
    );
    modport slave (
        input  wr_valid, wr_idx, wr_data, commit, en_mask, blink_mask,
        output wr_ready, busy
    );
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: 4-bit hex value to active-low 7-segment pattern (bit0=a .. bit6=g).
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);
    assign seg = hex_seg(val);
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of an NDIG-digit common-anode display
// with shadowed digit values published only at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int DIV          = 1000,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_ctrl_if.slave    bus,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an
);
    localparam int IW = $clog2(NDIG);
    localparam int CW = $clog2(DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    scan_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [FW-1:0]        frm_q, frm_d;
    logic                 phase_q, phase_d;
    logic                 busy_q, busy_d;
    logic [NDIG-1:0][3:0] shadow_q, shadow_d;
    logic [NDIG-1:0][3:0] active_q, active_d;
    logic [6:0]           seg_q, seg_d;
    logic [NDIG-1:0]      an_q, an_d;
    logic [6:0]           dec;
    logic                 slot_end, frame_end, frm_wrap, wr_fire, visible;

    hex7seg u_dec (.val(active_q[idx_q]), .seg(dec));

    always_comb begin
        slot_end  = cnt_q == CW'(DIV - 1);
        frame_end = slot_end && idx_q == IW'(NDIG - 1);
        frm_wrap  = frame_end && frm_q == FW'(BLINK_FRAMES - 1);
        wr_fire   = bus.wr_valid && !busy_q;
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = slot_end ? (frame_end ? '0 : idx_q + 1'b1) : idx_q;
        state_d   = slot_end ? ST_BLANK : cnt_q == CW'(BLANK - 1) ? ST_SHOW : state_q;
        frm_d     = frm_wrap ? '0 : frame_end ? frm_q + 1'b1 : frm_q;
        phase_d   = phase_q ^ frm_wrap;
        // A commit raised on the boundary cycle itself waits for the next frame.
        busy_d    = busy_q ? !frame_end : bus.commit;
        active_d  = frame_end && busy_q ? shadow_q : active_q;
        shadow_d  = shadow_q;
        for (int i = 0; i < NDIG; i++)
            if (wr_fire && bus.wr_idx == IW'(i)) shadow_d[i] = bus.wr_data;
        // Dark slots still take their full time so brightness does not depend on the masks.
        visible   = state_q == ST_SHOW && bus.en_mask[idx_q] && !(bus.blink_mask[idx_q] && phase_q);
        seg_d     = visible ? dec : SEG_BLANK;
        an_d      = visible ? ~(NDIG'(1) << idx_q) : '1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            frm_q    <= '0;
            phase_q  <= 1'b0;
            busy_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frm_q    <= frm_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end

    assign seg          = seg_q;
    assign an           = an_q;
    assign bus.busy     = busy_q;
    assign bus.wr_ready = !busy_q;
endmodule
